sram1024x18_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that wraps one sram1024x18 dual-port macro and turns it into a valid/ready stream buffer.
- Port A is write-only and port B is read-only.
- A 2-entry output prefetch buffer hides the macro's registered-input read latency, so the output sustains one word per cycle.
- Sits directly upstream of the macro and drives every macro input; the macro's rdata_b feeds back into this block.

---
 rtl/sram1024x18_fifo_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sram1024x18_fifo_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram1024x18_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sram1024x18_fifo_ctrl
//
// Synchronous valid/ready FIFO built around one sram1024x18 dual-port macro.
// Port A of the macro is used write-only and port B read-only. A two-entry
// prefetch buffer sits after port B so that the one-cycle registered read
// latency of the macro is hidden and the output can stream one word per cycle.
//
// Ports
//   clk, rst_n          single clock, synchronous active-low reset
//   flush               synchronous clear of pointers, counts and buffer
//   in_valid/in_ready   write-side handshake, in_data is the pushed word
//   out_valid/out_ready read-side handshake, out_data is the buffer head
//   level               words held (SRAM + read in flight + buffer)
//   empty/full/almost_full registered status flags
//   sram_*_a            macro port A (write) controls, active-low enables
//   sram_*_b            macro port B (read) controls, active-low enables
//   sram_rdata_b        macro port B read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module sram1024x18_fifo_ctrl #(
    parameter int DW        = 18,
    parameter int AW        = 10,
    parameter int AFULL_THR = 1020
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,

    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          almost_full,

    output logic          sram_cen_a,
    output logic          sram_wen_a,
    output logic [AW-1:0] sram_addr_a,
    output logic [DW-1:0] sram_wmsk_a,
    output logic [DW-1:0] sram_wdata_a,

    output logic          sram_cen_b,
    output logic          sram_wen_b,
    output logic [AW-1:0] sram_addr_b,
    output logic [DW-1:0] sram_wmsk_b,
    output logic [DW-1:0] sram_wdata_b,
    input  logic [DW-1:0] sram_rdata_b
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_THR);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] ZERO_C  = '0;

    // Pointers and counts
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   sram_cnt;     // words in SRAM not yet read-requested
    logic [AW:0]   level_q;
    logic          inflight;     // a port-B read was issued last cycle
    logic [1:0]    buf_cnt;
    logic [DW-1:0] buf0;         // head of the prefetch buffer
    logic [DW-1:0] buf1;

    // Registered status
    logic in_ready_q;
    logic empty_q;
    logic full_q;
    logic afull_q;

    // Combinational control
    logic          push;
    logic          pop;
    logic          rd_req;
    logic [2:0]    occ;
    logic [1:0]    buf_cnt_nxt;
    logic [1:0]    tail_idx;
    logic [AW:0]   sram_cnt_nxt;
    logic [AW:0]   level_nxt;

    // Flush and reset both win over any transfer this cycle. Gating push on
    // rst_n keeps port A quiet even before the first reset edge is seen.
    assign push = in_valid & in_ready_q & ~flush & rst_n;
    assign pop  = (buf_cnt != 2'd0) & out_ready & ~flush;

    // Downstream occupancy after this cycle's pop; a read may only be issued
    // when the returning word is guaranteed a free buffer slot.
    assign occ    = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_req = (sram_cnt != ZERO_C) & (occ < 3'd2) & ~flush & rst_n;

    // A pushed word is counted readable at the edge that commits it, so the
    // earliest read of it is the following cycle and the port A / port B
    // addresses can never coincide within one cycle.
    assign sram_cnt_nxt = sram_cnt + (push ? ONE_C : ZERO_C) - (rd_req ? ONE_C : ZERO_C);
    assign level_nxt    = level_q  + (push ? ONE_C : ZERO_C) - (pop    ? ONE_C : ZERO_C);

    assign buf_cnt_nxt = buf_cnt + {1'b0, inflight} - {1'b0, pop};
    // Slot that the returning read word lands in, after any pop shifts.
    assign tail_idx    = buf_cnt - {1'b0, pop};

    // Macro port A: write-only
    assign sram_cen_a   = ~push;
    assign sram_wen_a   = ~push;
    assign sram_addr_a  = wr_ptr;
    assign sram_wdata_a = push ? in_data : '0;
    assign sram_wmsk_a  = push ? '0 : '1;

    // Macro port B: read-only
    assign sram_cen_b   = ~rd_req;
    assign sram_wen_b   = 1'b1;
    assign sram_addr_b  = rd_ptr;
    assign sram_wmsk_b  = '1;
    assign sram_wdata_b = '0;

    // Stream side
    assign in_ready    = in_ready_q;
    assign out_valid   = (buf_cnt != 2'd0);
    assign out_data    = buf0;
    assign level       = level_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            // A read in flight is dropped simply by clearing inflight.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sram_cnt   <= '0;
            level_q    <= '0;
            inflight   <= 1'b0;
            buf_cnt    <= 2'd0;
            buf0       <= '0;
            in_ready_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_req) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            sram_cnt <= sram_cnt_nxt;
            level_q  <= level_nxt;
            inflight <= rd_req;
            buf_cnt  <= buf_cnt_nxt;

            // Capture stage: pop shifts first, the returning word then lands
            // in the tail (the later assignment wins when both hit buf0).
            if (pop) begin
                buf0 <= buf1;
            end
            if (inflight) begin
                if (tail_idx == 2'd0) begin
                    buf0 <= sram_rdata_b;
                end else begin
                    buf1 <= sram_rdata_b;
                end
            end

            in_ready_q <= (sram_cnt_nxt < DEPTH_C);
            full_q     <= !(sram_cnt_nxt < DEPTH_C);
            empty_q    <= (level_nxt == ZERO_C);
            afull_q    <= (level_nxt >= AFULL_C);
        end
    end

endmodule

// File: tb/tb_sram1024x18_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for sram1024x18_fifo_ctrl, including a behavioural model of the
// sram1024x18 macro (registered inputs, read data one cycle after request).
// Pushed words are queued as expected output; an independent monitor pops
// and compares every word the FIFO delivers.
// ---------------------------------------------------------------------------
module tb_sram1024x18_fifo_ctrl;

    localparam int DW = 18;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          sram_cen_a;
    logic          sram_wen_a;
    logic [AW-1:0] sram_addr_a;
    logic [DW-1:0] sram_wmsk_a;
    logic [DW-1:0] sram_wdata_a;
    logic          sram_cen_b;
    logic          sram_wen_b;
    logic [AW-1:0] sram_addr_b;
    logic [DW-1:0] sram_wmsk_b;
    logic [DW-1:0] sram_wdata_b;
    logic [DW-1:0] sram_rdata_b = '0;

    always #5 clk = ~clk;

    sram1024x18_fifo_ctrl #(.DW(DW), .AW(AW), .AFULL_THR(1020)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .empty(empty), .full(full), .almost_full(almost_full),
        .sram_cen_a(sram_cen_a), .sram_wen_a(sram_wen_a), .sram_addr_a(sram_addr_a),
        .sram_wmsk_a(sram_wmsk_a), .sram_wdata_a(sram_wdata_a),
        .sram_cen_b(sram_cen_b), .sram_wen_b(sram_wen_b), .sram_addr_b(sram_addr_b),
        .sram_wmsk_b(sram_wmsk_b), .sram_wdata_b(sram_wdata_b),
        .sram_rdata_b(sram_rdata_b)
    );

    // Macro model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_cen_a && !sram_wen_a)
            mem[sram_addr_a] <= (mem[sram_addr_a] & sram_wmsk_a) | (sram_wdata_a & ~sram_wmsk_a);
        if (!sram_cen_b && sram_wen_b)
            sram_rdata_b <= mem[sram_addr_b];
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int total_pops = 0;
    logic [DW-1:0] last_pop = '0;
    logic [DW-1:0] expq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_stall = 1'b0;
                continue;
            end
            if (!sram_cen_a && !sram_cen_b)
                chk("port_addr_distinct", {31'd0, sram_addr_a != sram_addr_b}, 32'd1);
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {14'd0, out_data}, {14'd0, prev_data});
            end
            if (flush) begin
                expq.delete();
                prev_stall = 1'b0;
                continue;
            end
            if (in_valid && in_ready) expq.push_back(in_data);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no word", out_data);
                end else begin
                    chk("out_data", {14'd0, out_data}, {14'd0, expq.pop_front()});
                end
                total_pops++;
                last_pop = out_data;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Push one word; returns at posedge+1 after it was accepted.
    task automatic push_word(input logic [DW-1:0] d, output logic [AW-1:0] addr);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: in_ready stuck at 0, expected 1");
        end
        addr = sram_addr_a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget, output int n);
        n = 0;
        while (total_pops < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (total_pops < target) begin
            tests++;
            fails++;
            $display("FAIL pop_timeout: got %0d words, expected %0d", total_pops, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int base, n, c1, c2;
        logic done;

        // Reset with in_valid held high
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 18'h3FFFF; out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_cen_a", {31'd0, sram_cen_a}, 32'd1);
        end
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {14'd0, out_data}, 32'd0);
        chk("rst_level", {21'd0, level}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_afull", {31'd0, almost_full}, 32'd0);
        chk("rst_cen_b", {31'd0, sram_cen_b}, 32'd1);
        chk("rst_wmsk_a", {14'd0, sram_wmsk_a}, 32'h3FFFF);
        chk("rst_wdata_a", {14'd0, sram_wdata_a}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("release_in_ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Single word, first-word latency
        in_valid = 1'b1; in_data = 18'h00001; out_ready = 1'b1;
        @(negedge clk);
        chk("c0_addr_a", {22'd0, sram_addr_a}, 32'd0);
        chk("c0_cen_a", {31'd0, sram_cen_a}, 32'd0);
        chk("c0_wen_a", {31'd0, sram_wen_a}, 32'd0);
        chk("c0_wmsk_a", {14'd0, sram_wmsk_a}, 32'd0);
        chk("c0_wdata_a", {14'd0, sram_wdata_a}, 32'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("c1_cen_b", {31'd0, sram_cen_b}, 32'd0);
        chk("c1_wen_b", {31'd0, sram_wen_b}, 32'd1);
        chk("c1_addr_b", {22'd0, sram_addr_b}, 32'd0);
        chk("c1_level", {21'd0, level}, 32'd1);
        chk("c1_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("c2_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("c3_out_valid", {31'd0, out_valid}, 32'd1);
        chk("c3_out_data", {14'd0, out_data}, 32'd1);
        @(negedge clk);
        chk("c4_level", {21'd0, level}, 32'd0);
        chk("c4_empty", {31'd0, empty}, 32'd1);
        chk("c4_out_valid", {31'd0, out_valid}, 32'd0);

        // Fill to capacity with the output stalled
        @(posedge clk); #1; out_ready = 1'b0;
        for (int k = 0; k < 1026; k++) begin
            push_word(18'(k), a);
            if (k + 1 == 1019) begin
                chk("fill1019_level", {21'd0, level}, 32'd1019);
                chk("fill1019_afull", {31'd0, almost_full}, 32'd0);
            end
            if (k + 1 == 1020) chk("fill1020_afull", {31'd0, almost_full}, 32'd1);
            if (k + 1 == 1025) chk("fill1025_in_ready", {31'd0, in_ready}, 32'd1);
        end
        chk("fill_level", {21'd0, level}, 32'd1026);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_afull", {31'd0, almost_full}, 32'd1);
        in_valid = 1'b1; in_data = 18'h3FFFF;
        repeat (4) begin
            @(negedge clk);
            chk("full_no_write", {31'd0, sram_cen_a}, 32'd1);
        end
        @(posedge clk); #1; in_valid = 1'b0;
        base = total_pops;
        out_ready = 1'b1;
        wait_pops(base + 1026, 3000, n);
        chk("drain_cycles", n, 32'd1026);
        repeat (2) @(posedge clk);
        #1;
        chk("drain_level", {21'd0, level}, 32'd0);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_full", {31'd0, full}, 32'd0);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd1);

        // Continuous stream of 3000 words, pointers wrap
        base = total_pops;
        c1 = 0; c2 = 0;
        fork
            begin
                for (int i = 0; i < 3000; i++) push_word(18'(i * 7 + 3), a);
            end
            begin
                wait_pops(base + 1, 100, n);
                c1 = cyc;
                wait_pops(base + 3000, 6000, n);
                c2 = cyc;
            end
        join
        chk("stream_no_bubbles", c2 - c1, 32'd2999);
        repeat (4) @(posedge clk);
        #1;
        chk("stream_level", {21'd0, level}, 32'd0);

        // Random back-pressure with continuous push
        base = total_pops;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5000; i++) push_word(18'(i * 13 + 5), a);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_pops(base + 5000, 4000, n);
        chk("random_count", total_pops - base, 32'd5000);
        chk("random_queue_empty", expq.size(), 32'd0);

        // Flush with a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(18'h100 + 18'(i), a);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_flush_level", {21'd0, level}, 32'd4);
        out_ready = 1'b1;
        @(negedge clk);
        chk("pre_flush_head", {14'd0, out_data}, 32'h100);
        chk("pre_flush_read", {31'd0, sram_cen_b}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_level", {21'd0, level}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        chk("flush_empty", {31'd0, empty}, 32'd1);
        base = total_pops;
        push_word(18'h2AAAA, a);
        chk("flush_next_addr", {22'd0, a}, 32'd0);
        out_ready = 1'b1;
        wait_pops(base + 1, 50, n);
        chk("flush_first_word", {14'd0, last_pop}, 32'h2AAAA);
        repeat (6) @(posedge clk);
        #1;
        chk("flush_no_stale", total_pops - base, 32'd1);
        chk("flush_final_level", {21'd0, level}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
